// File: rtl/dma_bus_arbiter_if.sv
// Bus bundle for dma_bus_arbiter: DMA hold/vramcs side, CPU side and memory side.
// The slave modport is the arbiter's view of the bus; the master modport is its environment's view.
interface dma_bus_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int STAT_W = 16
);
   logic              hold;
   logic              hlda;
   logic [ADDR_W-1:0] dma_addr;
   logic              dma_cs;
   logic [DATA_W-1:0] dma_data;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_dout;
   logic              cpu_rw;
   logic              cpu_vma;
   logic              cpu_ba;
   logic              cpu_halt;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;
   logic              mem_oe;
   logic              mem_we;
   logic              ba_timeout;
   logic [STAT_W-1:0] grant_cnt;

   modport slave (
      input  hold, dma_addr, dma_cs, cpu_addr, cpu_dout, cpu_rw, cpu_vma, cpu_ba, mem_din,
      output hlda, dma_data, cpu_halt, mem_addr, mem_dout, mem_oe, mem_we, ba_timeout, grant_cnt
   );

   modport master (
      output hold, dma_addr, dma_cs, cpu_addr, cpu_dout, cpu_rw, cpu_vma, cpu_ba, mem_din,
      input  hlda, dma_data, cpu_halt, mem_addr, mem_dout, mem_oe, mem_we, ba_timeout, grant_cnt
   );
endinterface

// File: rtl/dma_bus_arbiter.sv
// Video DMA bus arbiter: halts the 6800 CPU on hold, grants the memory bus to DMA, returns it.
// Optional grant-cycle statistics counter enabled by defining DMA_STATS_EN.
module dma_bus_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 8,
   parameter int BA_TIMEOUT = 15,
   parameter int STAT_W     = 16
) (
   input logic               clk,
   input logic               rst,
   dma_bus_arbiter_if.slave  bus
);
   localparam int CNT_W = (BA_TIMEOUT < 2) ? 1 : $clog2(BA_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TMO = CNT_W'(BA_TIMEOUT);
   localparam bit TMO_EN = (BA_TIMEOUT != 0);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HALT_REQ = 2'd1,
      GRANT    = 2'd2,
      RELEASE  = 2'd3
   } state_e;

   state_e            state_q;
   logic              hlda_q;
   logic              cpu_halt_q;
   logic              ba_timeout_q;
   logic [CNT_W-1:0]  wait_q;
   logic [CNT_W-1:0]  wait_d;
   logic [DATA_W-1:0] dma_data_q;
   logic [ADDR_W-1:0] mem_addr_s;
   logic [DATA_W-1:0] mem_dout_s;
   logic              mem_oe_s;
   logic              mem_we_s;

   assign wait_d = wait_q + CNT_W'(1'b1);

   // Arbitration FSM; a hold seen in RELEASE is only acted on once back in IDLE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         hlda_q       <= 1'b0;
         cpu_halt_q   <= 1'b0;
         ba_timeout_q <= 1'b0;
         wait_q       <= {CNT_W{1'b0}};
         dma_data_q   <= {DATA_W{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.hold) begin
                  state_q    <= HALT_REQ;
                  cpu_halt_q <= 1'b1;
                  wait_q     <= {CNT_W{1'b0}};
               end else begin
                  state_q <= IDLE;
               end
            end
            HALT_REQ: begin
               if (bus.cpu_ba) begin
                  state_q <= GRANT;
                  hlda_q  <= 1'b1;
               end else if (!bus.hold) begin
                  state_q <= RELEASE;
               end else if (TMO_EN && (wait_q == TMO)) begin
                  state_q      <= GRANT;
                  hlda_q       <= 1'b1;
                  ba_timeout_q <= 1'b1;
               end else begin
                  wait_q <= wait_d;
               end
            end
            GRANT: begin
               if (!bus.hold) begin
                  state_q <= RELEASE;
                  hlda_q  <= 1'b0;
               end else begin
                  state_q <= GRANT;
               end
            end
            RELEASE: begin
               state_q    <= IDLE;
               hlda_q     <= 1'b0;
               cpu_halt_q <= 1'b0;
            end
            default: begin
               state_q    <= IDLE;
               hlda_q     <= 1'b0;
               cpu_halt_q <= 1'b0;
            end
         endcase
         if (hlda_q && bus.dma_cs) begin
            dma_data_q <= bus.mem_din;
         end
      end
   end

   // Memory bus steering from the registered grant; DMA side can only read.
   always_comb begin
      mem_addr_s = bus.cpu_addr;
      mem_dout_s = bus.cpu_dout;
      mem_oe_s   = 1'b0;
      mem_we_s   = 1'b0;
      if (hlda_q) begin
         mem_addr_s = bus.dma_addr;
         mem_dout_s = {DATA_W{1'b0}};
         mem_oe_s   = bus.dma_cs;
         mem_we_s   = 1'b0;
      end else begin
         mem_addr_s = bus.cpu_addr;
         mem_dout_s = bus.cpu_dout;
         mem_oe_s   = bus.cpu_vma & bus.cpu_rw;
         mem_we_s   = bus.cpu_vma & ~bus.cpu_rw;
      end
   end

`ifdef DMA_STATS_EN
   logic [STAT_W-1:0] grant_cnt_q;
   logic [STAT_W-1:0] grant_cnt_d;

   // Saturating count of cycles spent in GRANT.
   always_comb begin
      grant_cnt_d = grant_cnt_q;
      if ((state_q == GRANT) && (grant_cnt_q != {STAT_W{1'b1}})) begin
         grant_cnt_d = grant_cnt_q + STAT_W'(1'b1);
      end else begin
         grant_cnt_d = grant_cnt_q;
      end
   end

   // Statistics register, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         grant_cnt_q <= {STAT_W{1'b0}};
      end else begin
         grant_cnt_q <= grant_cnt_d;
      end
   end

   assign bus.grant_cnt = grant_cnt_q;
`else
   assign bus.grant_cnt = {STAT_W{1'b0}};
`endif

   assign bus.hlda       = hlda_q;
   assign bus.cpu_halt   = cpu_halt_q;
   assign bus.ba_timeout = ba_timeout_q;
   assign bus.dma_data   = dma_data_q;
   assign bus.mem_addr   = mem_addr_s;
   assign bus.mem_dout   = mem_dout_s;
   assign bus.mem_oe     = mem_oe_s;
   assign bus.mem_we     = mem_we_s;
endmodule
